// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared register-file writeback types
package mips_core_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;

    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] addr;
        logic [RF_DATA_WIDTH-1:0] data;
    } rf_write_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } rr_src_t;

    function automatic rr_src_t other_src(input rr_src_t src);
        return (src == SRC_A) ? SRC_B : SRC_A;
    endfunction

endpackage

// File: rtl/reg_write_port_arbiter_fifo.sv
// rtl/reg_write_port_arbiter_fifo.sv - per-source writeback queue with entry visibility for hazard lookup
module reg_write_fifo
    import mips_core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                push,
    input  rf_write_t                           din,
    input  logic                                pop,
    output logic                                full,
    output logic                                empty,
    output rf_write_t                           head,
    output logic [DEPTH-1:0]                    entry_valid,
    output logic [DEPTH-1:0][RF_ADDR_WIDTH-1:0] entry_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rf_write_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        entry_valid = '0;
        entry_addr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] offset;
            offset         = PTR_W'(i) - rd_ptr;
            entry_valid[i] = (CNT_W'(offset) < count);
            entry_addr[i]  = mem[i].addr;
        end
    end

endmodule

// File: rtl/reg_write_port_arbiter.sv
// rtl/reg_write_port_arbiter.sv - round-robin sharing of the register file write port between two writeback sources
module reg_write_port_arbiter
    import mips_core_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  wb_uses_rw,
    output logic [ADDR_WIDTH-1:0] wb_rw_addr,
    output logic [DATA_WIDTH-1:0] wb_rw_data,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    output logic                  rs_pending,
    output logic                  rt_pending
);

    logic      a_full, a_empty, b_full, b_empty;
    logic      a_push, b_push;
    logic      grant_a, grant_b;
    rf_write_t a_head, b_head;
    rf_write_t a_entry, b_entry;
    rr_src_t   rr_ptr;

    logic [DEPTH-1:0]                    a_entry_valid, b_entry_valid;
    logic [DEPTH-1:0][RF_ADDR_WIDTH-1:0] a_entry_addr, b_entry_addr;

    assign a_ready = rst_n & ~a_full;
    assign b_ready = rst_n & ~b_full;

    // Writes to register zero complete the handshake but are dropped here.
    assign a_push  = a_valid & a_ready & (a_addr != '0);
    assign b_push  = b_valid & b_ready & (b_addr != '0);
    assign a_entry = '{addr: a_addr, data: a_data};
    assign b_entry = '{addr: b_addr, data: b_data};

    reg_write_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (a_push),
        .din         (a_entry),
        .pop         (grant_a),
        .full        (a_full),
        .empty       (a_empty),
        .head        (a_head),
        .entry_valid (a_entry_valid),
        .entry_addr  (a_entry_addr)
    );

    reg_write_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (b_push),
        .din         (b_entry),
        .pop         (grant_b),
        .full        (b_full),
        .empty       (b_empty),
        .head        (b_head),
        .entry_valid (b_entry_valid),
        .entry_addr  (b_entry_addr)
    );

    assign grant_a = ~a_empty & (b_empty | (rr_ptr == SRC_A));
    assign grant_b = ~b_empty & ~grant_a;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_uses_rw <= 1'b0;
            wb_rw_addr <= '0;
            wb_rw_data <= '0;
            rr_ptr     <= SRC_A;
        end else begin
            wb_uses_rw <= grant_a | grant_b;
            if (grant_a) begin
                wb_rw_addr <= a_head.addr;
                wb_rw_data <= a_head.data;
                rr_ptr     <= other_src(SRC_A);
            end else if (grant_b) begin
                wb_rw_addr <= b_head.addr;
                wb_rw_data <= b_head.data;
                rr_ptr     <= other_src(SRC_B);
            end
        end
    end

    // A register is in flight while it sits in either queue or on the write port.
    always_comb begin
        rs_pending = wb_uses_rw & (wb_rw_addr == rs_addr);
        rt_pending = wb_uses_rw & (wb_rw_addr == rt_addr);
        for (int i = 0; i < DEPTH; i++) begin
            rs_pending |= a_entry_valid[i] & (a_entry_addr[i] == rs_addr);
            rs_pending |= b_entry_valid[i] & (b_entry_addr[i] == rs_addr);
            rt_pending |= a_entry_valid[i] & (a_entry_addr[i] == rt_addr);
            rt_pending |= b_entry_valid[i] & (b_entry_addr[i] == rt_addr);
        end
        rs_pending &= (rs_addr != '0);
        rt_pending &= (rt_addr != '0);
    end

endmodule

// File: tb/tb_reg_write_port_arbiter.sv
// tb/tb_reg_write_port_arbiter.sv - directed checks of the writeback port arbiter
module tb_reg_write_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        wb_uses_rw;
    logic [4:0]  wb_rw_addr;
    logic [31:0] wb_rw_data;
    logic [4:0]  rs_addr, rt_addr;
    logic        rs_pending, rt_pending;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    reg_write_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .wb_uses_rw (wb_uses_rw),
        .wb_rw_addr (wb_rw_addr),
        .wb_rw_data (wb_rw_data),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_pending (rs_pending),
        .rt_pending (rt_pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          ia, ib;
    bit          xa, xb;
    bit          saw_b_full;
    int          first_cyc, last_cyc;
    logic [31:0] got_addr [$];
    logic [31:0] exp_seq  [8];

    initial begin
        rst_n   = 1'b0;
        a_valid = 1'b1;
        a_addr  = 5'd3;
        a_data  = 32'h0;
        b_valid = 1'b0;
        b_addr  = 5'd0;
        b_data  = 32'h0;
        rs_addr = 5'd0;
        rt_addr = 5'd0;

        // reset holds ready low even with valid asserted
        repeat (3) @(negedge clk);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_wb_uses", wb_uses_rw, 0);
        check("rst_wb_addr", wb_rw_addr, 0);
        check("rst_wb_data", wb_rw_data, 0);
        rst_n   = 1'b1;
        a_valid = 1'b0;
        @(negedge clk);
        check("rel_a_ready", a_ready, 1);
        check("rel_b_ready", b_ready, 1);

        // single write latency and pending window
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF; rs_addr = 5'd5;
        #1 check("t2_a_ready", a_ready, 1);
        @(negedge clk);
        a_valid = 1'b0;
        check("t2_n_uses", wb_uses_rw, 0);
        check("t2_n_pend", rs_pending, 1);
        @(negedge clk);
        check("t2_n1_uses", wb_uses_rw, 1);
        check("t2_n1_addr", wb_rw_addr, 5);
        check("t2_n1_data", wb_rw_data, 32'hDEADBEEF);
        check("t2_n1_pend", rs_pending, 1);
        @(negedge clk);
        check("t2_n2_uses", wb_uses_rw, 0);
        check("t2_n2_pend", rs_pending, 0);
        check("t2_n2_hold", wb_rw_addr, 5);

        // same-register collision, pointer at B after the lone A grant
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h1;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h2;
        rt_addr = 5'd7;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        check("t5_q_uses", wb_uses_rw, 0);
        check("t5_q_pend", rt_pending, 1);
        @(negedge clk);
        check("t5_w1_uses", wb_uses_rw, 1);
        check("t5_w1_addr", wb_rw_addr, 7);
        check("t5_w1_data", wb_rw_data, 32'h2);
        check("t5_w1_pend", rt_pending, 1);
        @(negedge clk);
        check("t5_w2_uses", wb_uses_rw, 1);
        check("t5_w2_addr", wb_rw_addr, 7);
        check("t5_w2_data", wb_rw_data, 32'h1);
        check("t5_w2_pend", rt_pending, 1);
        @(negedge clk);
        check("t5_end_uses", wb_uses_rw, 0);
        check("t5_end_pend", rt_pending, 0);

        // register zero is accepted and discarded
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF; rs_addr = 5'd0;
        #1 check("t4_a_ready", a_ready, 1);
        @(negedge clk);
        a_valid = 1'b0;
        check("t4_uses0", wb_uses_rw, 0);
        check("t4_pend", rs_pending, 0);
        @(negedge clk);
        check("t4_uses1", wb_uses_rw, 0);
        check("t4_hold_data", wb_rw_data, 32'h1);

        // load both queues, then a one-cycle reset discards everything
        a_valid = 1'b1; a_addr = 5'd20; a_data = 32'hA0;
        b_valid = 1'b1; b_addr = 5'd22; b_data = 32'hB0;
        rs_addr = 5'd20; rt_addr = 5'd22;
        repeat (3) @(negedge clk);
        check("t6_pre_rs", rs_pending, 1);
        check("t6_pre_rt", rt_pending, 1);
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        #1 check("t6_rst_a_ready", a_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_post_addr", wb_rw_addr, 0);
        for (int k = 0; k < 4; k++) begin
            check("t6_post_uses", wb_uses_rw, 0);
            check("t6_post_rs", rs_pending, 0);
            check("t6_post_rt", rt_pending, 0);
            @(negedge clk);
        end

        // contention from reset pointer: strict alternation, no bubbles
        exp_seq = '{32'd1, 32'd11, 32'd2, 32'd12, 32'd3, 32'd13, 32'd4, 32'd14};
        ia = 0; ib = 0; saw_b_full = 1'b0; first_cyc = -1; last_cyc = -1;
        rs_addr = 5'd0; rt_addr = 5'd0;
        a_valid = 1'b1; a_addr = 5'd1;  a_data = 32'h100;
        b_valid = 1'b1; b_addr = 5'd11; b_data = 32'h200;
        for (int cyc = 0; cyc < 40 && got_addr.size() < 8; cyc++) begin
            if (!b_ready) saw_b_full = 1'b1;
            xa = a_valid && a_ready;
            xb = b_valid && b_ready;
            @(negedge clk);
            if (xa) ia++;
            if (xb) ib++;
            if (wb_uses_rw) begin
                got_addr.push_back(32'(wb_rw_addr));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            a_valid = (ia < 4); a_addr = 5'(ia + 1);  a_data = 32'h100 + 32'(ia);
            b_valid = (ib < 4); b_addr = 5'(ib + 11); b_data = 32'h200 + 32'(ib);
        end
        check("t3_count", got_addr.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_seq%0d", i), (i < got_addr.size()) ? got_addr[i] : 32'hFFFF_FFFF, exp_seq[i]);
        end
        check("t3_no_gaps", 32'(last_cyc - first_cyc), 7);
        check("t3_b_ready_drop", 32'(saw_b_full), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
